// File: rtl/multicycle_pkg.sv
// Shared encodings and types for the multi-cycle core: opcodes, R-type funcs,
// ALU operations, FSM states and the instruction word layout.
package multicycle_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLLV = 6'h04;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLL
  } alu_op_t;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, WB, HALT
  } state_t;

  // I-type imm16 occupies {func, rsvd, rd}
  typedef struct packed {
    logic [5:0] func;
    logic [4:0] rsvd;
    logic [4:0] rd;
    logic [4:0] rt;
    logic [4:0] rs;
    logic [5:0] op;
  } instr_t;

endpackage

// File: rtl/multicycle_core_alu.sv
// Combinational ALU for the multi-cycle core.
module core_alu
  import multicycle_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] y_c
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  always_comb begin
    y_c = '0;
    case (op)
      ALU_ADD: y_c = a + b;
      ALU_SUB: y_c = a - b;
      ALU_AND: y_c = a & b;
      ALU_OR:  y_c = a | b;
      ALU_XOR: y_c = a ^ b;
      ALU_NOR: y_c = ~(a | b);
      ALU_SLT: y_c = DATA_W'($signed(a) < $signed(b));
      ALU_SLL: y_c = a << b[SH_W-1:0];
      default: y_c = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle CPU core: FETCH/DECODE/EXEC/WB over a req/ack instruction memory,
// with internal register file, PC, and a retire observation port.
module multicycle_core
  import multicycle_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned PC_W     = 8,
  parameter int unsigned NREG     = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              retire,
  output logic [PC_W-1:0]   retire_pc,
  output logic              retire_we,
  output logic [4:0]        retire_rd,
  output logic [DATA_W-1:0] retire_data,
  output logic              illegal,
  output logic              halted
);

  localparam int unsigned RIDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  state_t              state_q, state_d;
  instr_t              ir_q;
  logic [PC_W-1:0]     pc_q;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   a_q, b_q, res_q;
  logic                taken_q;

  logic [5:0]          op_c;
  logic [15:0]         imm_c;
  logic [DATA_W-1:0]   imm_ext_c;
  alu_op_t             alu_op_c;
  logic                legal_c, writes_c, use_imm_c, is_beq_c, we_c;
  logic [4:0]          dest_c;
  logic [RIDX_W-1:0]   dest_idx_c, rs_idx_c, rt_idx_c;
  logic [DATA_W-1:0]   alu_b_c, alu_y_c;
  logic [PC_W-1:0]     pc_inc_c, pc_br_c;

  // Instruction decode from the IR
  always_comb begin
    op_c      = ir_q.op;
    imm_c     = {ir_q.func, ir_q.rsvd, ir_q.rd};
    imm_ext_c = DATA_W'($signed(imm_c));
    alu_op_c  = ALU_ADD;
    legal_c   = 1'b0;
    writes_c  = 1'b0;
    use_imm_c = 1'b0;
    is_beq_c  = 1'b0;
    dest_c    = ir_q.rd;
    case (op_c)
      OP_RTYPE: begin
        legal_c  = 1'b1;
        writes_c = 1'b1;
        case (ir_q.func)
          FN_ADD:  alu_op_c = ALU_ADD;
          FN_SUB:  alu_op_c = ALU_SUB;
          FN_AND:  alu_op_c = ALU_AND;
          FN_OR:   alu_op_c = ALU_OR;
          FN_XOR:  alu_op_c = ALU_XOR;
          FN_NOR:  alu_op_c = ALU_NOR;
          FN_SLT:  alu_op_c = ALU_SLT;
          FN_SLLV: alu_op_c = ALU_SLL;
          default: begin
            legal_c  = 1'b0;
            writes_c = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        legal_c   = 1'b1;
        writes_c  = 1'b1;
        use_imm_c = 1'b1;
        dest_c    = ir_q.rt;
      end
      OP_BEQ: begin
        legal_c  = 1'b1;
        is_beq_c = 1'b1;
      end
      OP_HALT: legal_c = 1'b1;
      default: legal_c = 1'b0;
    endcase
    rs_idx_c   = ir_q.rs[RIDX_W-1:0];
    rt_idx_c   = ir_q.rt[RIDX_W-1:0];
    dest_idx_c = dest_c[RIDX_W-1:0];
    we_c       = writes_c && (dest_idx_c != '0);
    alu_b_c    = use_imm_c ? imm_ext_c : b_q;
    pc_inc_c   = pc_q + PC_W'(4);
    pc_br_c    = pc_inc_c + PC_W'({{14{imm_c[15]}}, imm_c, 2'b00});
  end

  core_alu #(.DATA_W(DATA_W)) u_alu (
    .a   (a_q),
    .b   (alu_b_c),
    .op  (alu_op_c),
    .y_c (alu_y_c)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (imem_ack) state_d = DECODE;
      DECODE:  state_d = (op_c == OP_HALT) ? HALT : EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Moore outputs; HALT retires from DECODE since it never reaches WB
  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    retire      = 1'b0;
    retire_pc   = '0;
    retire_we   = 1'b0;
    retire_rd   = '0;
    retire_data = '0;
    illegal     = 1'b0;
    halted      = 1'b0;
    case (state_q)
      FETCH:  imem_req = !RST;
      DECODE: begin
        if (op_c == OP_HALT) begin
          retire    = 1'b1;
          retire_pc = pc_q;
        end
      end
      WB: begin
        retire      = 1'b1;
        retire_pc   = pc_q;
        retire_we   = we_c;
        retire_rd   = we_c ? dest_c : 5'd0;
        retire_data = we_c ? res_q : '0;
        illegal     = !legal_c;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q    <= PC_W'(RESET_PC);
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      taken_q <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        FETCH: if (imem_ack) ir_q <= instr_t'(imem_rdata);
        DECODE: begin
          a_q <= regs_q[rs_idx_c];
          b_q <= regs_q[rt_idx_c];
        end
        EXEC: begin
          res_q   <= alu_y_c;
          taken_q <= (a_q == b_q);
        end
        WB: begin
          pc_q <= (is_beq_c && taken_q) ? pc_br_c : pc_inc_c;
          if (we_c) regs_q[dest_idx_c] <= res_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Self-checking bench for multicycle_core: ISA model feeds a retire scoreboard,
// scenario tasks check timing, handshake and boundary behaviour.
module tb_multicycle_core;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PC_W   = 8;
  localparam int unsigned NREG   = 32;

  logic              CLK = 1'b0;
  logic              RST;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              retire;
  logic [PC_W-1:0]   retire_pc;
  logic              retire_we;
  logic [4:0]        retire_rd;
  logic [DATA_W-1:0] retire_data;
  logic              illegal;
  logic              halted;

  multicycle_core #(.DATA_W(DATA_W), .PC_W(PC_W), .NREG(NREG), .RESET_PC(0)) dut (
    .CLK(CLK), .RST(RST),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .retire(retire), .retire_pc(retire_pc), .retire_we(retire_we), .retire_rd(retire_rd),
    .retire_data(retire_data), .illegal(illegal), .halted(halted)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              we;
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
    logic              ill;
  } ret_t;

  ret_t              exp_q[$];
  ret_t              mon_e;
  logic [31:0]       mem [64];
  logic [DATA_W-1:0] mreg [32];
  int                n_checks = 0;
  int                n_fail = 0;
  int                cyc = 0;
  int                ret_cnt = 0;
  int                ack_delay = 0;
  int                wait_cnt = 0;
  bit                stray = 1'b0;
  int                ret_cyc [16];
  logic [DATA_W-1:0] ret_data [16];
  logic [PC_W-1:0]   ret_pcl [16];
  logic              ret_wel [16];
  logic              ret_ill [16];

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {fn, 5'd0, rd, rt, rs, 6'h00};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {imm, rt, rs, op};
  endfunction

  // Instruction memory responder with programmable wait states and stray acks
  always @(negedge CLK) begin
    if (RST || !imem_req) begin
      imem_ack   = stray;
      imem_rdata = stray ? enc_i(6'h08, 5'd0, 5'd6, 16'd99) : 32'h0;
      wait_cnt   = 0;
    end else if (wait_cnt >= ack_delay) begin
      imem_ack   = 1'b1;
      imem_rdata = mem[imem_addr[PC_W-1:2]];
    end else begin
      imem_ack = 1'b0;
      wait_cnt++;
    end
  end

  // Retire monitor: logs each retirement and checks it against the scoreboard
  always @(negedge CLK) begin
    if (RST) cyc = 0;
    else begin
      cyc++;
      if (retire) begin
        if (ret_cnt < 16) begin
          ret_cyc[ret_cnt]  = cyc;
          ret_data[ret_cnt] = retire_data;
          ret_pcl[ret_cnt]  = retire_pc;
          ret_wel[ret_cnt]  = retire_we;
          ret_ill[ret_cnt]  = illegal;
        end
        ret_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: retire at pc %0h, scoreboard empty", retire_pc);
        end else begin
          mon_e = exp_q.pop_front();
          if (retire_pc !== mon_e.pc) begin
            n_fail++;
            $display("FAIL sb_pc: got %0h want %0h", retire_pc, mon_e.pc);
          end
          n_checks++;
          if (retire_we !== mon_e.we) begin
            n_fail++;
            $display("FAIL sb_we: pc %0h got %0b want %0b", mon_e.pc, retire_we, mon_e.we);
          end
          n_checks++;
          if (illegal !== mon_e.ill) begin
            n_fail++;
            $display("FAIL sb_illegal: pc %0h got %0b want %0b", mon_e.pc, illegal, mon_e.ill);
          end
          if (mon_e.we) begin
            n_checks++;
            if (retire_rd !== mon_e.rd) begin
              n_fail++;
              $display("FAIL sb_rd: pc %0h got %0d want %0d", mon_e.pc, retire_rd, mon_e.rd);
            end
            n_checks++;
            if (retire_data !== mon_e.data) begin
              n_fail++;
              $display("FAIL sb_data: pc %0h got %0h want %0h", mon_e.pc, retire_data, mon_e.data);
            end
          end
        end
      end
    end
  end

  // Reference ISA model: walks memory from PC 0 and queues expected retirements
  task automatic model_run(input int max_n);
    logic [PC_W-1:0]   pc;
    logic [31:0]       ins;
    ret_t              r;
    logic [5:0]        op, fn;
    logic [4:0]        rs, rt, rd, dst;
    logic [15:0]       imm;
    logic [DATA_W-1:0] a, b, res, sx;
    logic              wr;
    for (int k = 0; k < 32; k++) mreg[k] = '0;
    pc = '0;
    for (int n = 0; n < max_n; n++) begin
      ins = mem[pc[PC_W-1:2]];
      op = ins[5:0];   rs = ins[10:6];   rt = ins[15:11];
      rd = ins[20:16]; fn = ins[31:26];  imm = ins[31:16];
      a = mreg[rs]; b = mreg[rt]; sx = {{16{imm[15]}}, imm};
      r = '0; r.pc = pc; wr = 1'b0; dst = rd; res = '0;
      if (op == 6'h3F) begin
        exp_q.push_back(r);
        break;
      end
      if (op == 6'h00) begin
        wr = 1'b1;
        case (fn)
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h26: res = a ^ b;
          6'h27: res = ~(a | b);
          6'h2A: res = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
          6'h04: res = a << b[4:0];
          default: begin wr = 1'b0; r.ill = 1'b1; end
        endcase
      end else if (op == 6'h08) begin
        wr = 1'b1; dst = rt; res = a + sx;
      end else if (op != 6'h04) begin
        r.ill = 1'b1;
      end
      if (wr && dst != 5'd0) begin
        r.we = 1'b1; r.rd = dst; r.data = res; mreg[dst] = res;
      end
      exp_q.push_back(r);
      if (op == 6'h04 && a == b) pc = pc + PC_W'(4) + PC_W'(sx << 2);
      else                       pc = pc + PC_W'(4);
    end
  endtask

  task automatic hold_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    exp_q.delete();
    ret_cnt = 0;
    for (int k = 0; k < 64; k++) mem[k] = 32'h0000_003F;
  endtask

  task automatic release_reset();
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic wait_retires(input int target, input int budget, input string name);
    int t = 0;
    while (ret_cnt < target && t < budget) begin
      @(negedge CLK);
      #1;
      t++;
    end
    n_checks++;
    if (ret_cnt < target) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d retires seen, need %0d", name, ret_cnt, target);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; stray = 1'b0; ack_delay = 0;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %0b want 0", imem_req); end
    n_checks++;
    if (imem_addr !== '0) begin n_fail++; $display("FAIL rst_addr: got %0h want 0", imem_addr); end
    n_checks++;
    if ({retire, retire_we, illegal, halted} !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_flags: got %b want 0000", {retire, retire_we, illegal, halted});
    end
    n_checks++;
    if (retire_data !== '0) begin n_fail++; $display("FAIL rst_data: got %0h want 0", retire_data); end
  endtask

  task automatic test_alu();
    hold_reset();
    mem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    mem[2]  = enc_r(6'h20, 5'd3, 5'd1, 5'd2);
    mem[3]  = enc_r(6'h2A, 5'd4, 5'd2, 5'd1);
    mem[4]  = enc_r(6'h22, 5'd5, 5'd2, 5'd1);
    mem[5]  = enc_r(6'h24, 5'd6, 5'd1, 5'd2);
    mem[6]  = enc_r(6'h25, 5'd7, 5'd1, 5'd2);
    mem[7]  = enc_r(6'h26, 5'd8, 5'd1, 5'd2);
    mem[8]  = enc_r(6'h27, 5'd9, 5'd1, 5'd2);
    mem[9]  = enc_r(6'h04, 5'd10, 5'd1, 5'd1);
    mem[10] = enc_r(6'h2A, 5'd11, 5'd1, 5'd2);
    model_run(20);
    release_reset();
    wait_retires(12, 300, "alu");
    n_checks++;
    if (ret_cyc[0] !== 4 || ret_cyc[1] !== 8) begin
      n_fail++; $display("FAIL alu_cycles: got %0d,%0d want 4,8", ret_cyc[0], ret_cyc[1]);
    end
    n_checks++;
    if (ret_data[0] !== 32'd5 || ret_data[1] !== 32'hFFFF_FFFD) begin
      n_fail++; $display("FAIL addi_data: got %0h,%0h want 5,fffffffd", ret_data[0], ret_data[1]);
    end
    n_checks++;
    if (ret_pcl[0] !== 8'd0 || ret_pcl[1] !== 8'd4) begin
      n_fail++; $display("FAIL addi_pc: got %0h,%0h want 0,4", ret_pcl[0], ret_pcl[1]);
    end
    n_checks++;
    if (ret_data[2] !== 32'd2 || ret_data[3] !== 32'd1 || ret_data[4] !== 32'hFFFF_FFF8) begin
      n_fail++;
      $display("FAIL add_slt_sub: got %0h,%0h,%0h want 2,1,fffffff8", ret_data[2], ret_data[3], ret_data[4]);
    end
    @(posedge CLK);
    #1;
    n_checks++;
    if (halted !== 1'b1 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL alu_halt: halted %0b req %0b want 1 0", halted, imem_req);
    end
  endtask

  task automatic test_beq();
    hold_reset();
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    mem[2] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFE);
    model_run(3);
    release_reset();
    wait_retires(3, 100, "beq_taken");
    @(posedge CLK);
    #1;
    n_checks++;
    if (imem_addr !== 8'd4 || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL beq_taken_addr: got %0h req %0b want 4 1", imem_addr, imem_req);
    end
    hold_reset();
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    mem[2] = enc_i(6'h04, 5'd1, 5'd2, 16'hFFFE);
    model_run(10);
    release_reset();
    wait_retires(3, 100, "beq_not");
    @(posedge CLK);
    #1;
    n_checks++;
    if (imem_addr !== 8'd12) begin
      n_fail++; $display("FAIL beq_not_addr: got %0h want c", imem_addr);
    end
    wait_retires(4, 50, "beq_halt");
  endtask

  task automatic test_wait();
    hold_reset();
    ack_delay = 3;
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    model_run(10);
    release_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      #1;
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'd0) begin
        n_fail++; $display("FAIL wait_stable: cycle %0d req %0b addr %0h want 1 0", i, imem_req, imem_addr);
      end
    end
    @(posedge CLK);
    #1 stray = 1'b1;
    repeat (2) @(posedge CLK);
    #1 stray = 1'b0;
    wait_retires(1, 50, "wait");
    n_checks++;
    if (ret_cyc[0] !== 7) begin
      n_fail++; $display("FAIL wait_latency: got cycle %0d want 7", ret_cyc[0]);
    end
    wait_retires(2, 50, "wait_halt");
    stray = 1'b1;
    repeat (5) @(negedge CLK);
    #1;
    n_checks++;
    if (halted !== 1'b1 || imem_req !== 1'b0 || ret_cnt !== 2 || imem_addr !== 8'd4) begin
      n_fail++;
      $display("FAIL stray_in_halt: halted %0b req %0b retires %0d addr %0h want 1 0 2 4",
               halted, imem_req, ret_cnt, imem_addr);
    end
    stray = 1'b0;
    ack_delay = 0;
  endtask

  task automatic test_r0_illegal();
    hold_reset();
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd4);
    mem[1] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    mem[2] = enc_r(6'h20, 5'd8, 5'd0, 5'd1);
    mem[3] = enc_r(6'h3E, 5'd9, 5'd1, 5'd1);
    mem[4] = enc_i(6'h08, 5'd9, 5'd10, 16'd1);
    mem[5] = enc_i(6'h15, 5'd1, 5'd11, 16'd3);
    model_run(20);
    release_reset();
    wait_retires(7, 200, "r0_ill");
    n_checks++;
    if (ret_wel[1] !== 1'b0) begin n_fail++; $display("FAIL r0_we: got %0b want 0", ret_wel[1]); end
    n_checks++;
    if (ret_data[2] !== 32'd4) begin n_fail++; $display("FAIL r0_read: got %0h want 4", ret_data[2]); end
    n_checks++;
    if (ret_ill[3] !== 1'b1 || ret_wel[3] !== 1'b0 || ret_pcl[4] !== 8'd16) begin
      n_fail++;
      $display("FAIL bad_func: ill %0b we %0b next pc %0h want 1 0 10", ret_ill[3], ret_wel[3], ret_pcl[4]);
    end
    n_checks++;
    if (ret_data[4] !== 32'd1 || ret_ill[5] !== 1'b1) begin
      n_fail++; $display("FAIL bad_op: data %0h ill %0b want 1 1", ret_data[4], ret_ill[5]);
    end
  endtask

  task automatic test_halt();
    int bad = 0;
    hold_reset();
    for (int k = 0; k < 4; k++) mem[k] = enc_i(6'h08, 5'd1, 5'd1, 16'd1);
    model_run(10);
    release_reset();
    wait_retires(5, 100, "halt");
    n_checks++;
    if (ret_pcl[4] !== 8'd16 || ret_wel[4] !== 1'b0) begin
      n_fail++; $display("FAIL halt_retire: pc %0h we %0b want 10 0", ret_pcl[4], ret_wel[4]);
    end
    @(posedge CLK);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      #1;
      if (halted !== 1'b1 || imem_req !== 1'b0 || retire !== 1'b0 || imem_addr !== 8'd16) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL halt_hold: %0d bad cycles want 0", bad); end
  endtask

  task automatic test_reset_mid_fetch();
    hold_reset();
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1] = enc_i(6'h08, 5'd1, 5'd2, 16'd1);
    model_run(1);
    release_reset();
    wait_retires(1, 50, "mid_first");
    ack_delay = 6;
    @(posedge CLK);
    repeat (2) @(negedge CLK);
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'd4) begin
      n_fail++; $display("FAIL mid_fetch_pre: req %0b addr %0h want 1 4", imem_req, imem_addr);
    end
    #2 RST = 1'b1;
    stray = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== 8'd0) begin
      n_fail++; $display("FAIL mid_fetch_rst: req %0b addr %0h want 0 0", imem_req, imem_addr);
    end
    repeat (3) @(posedge CLK);
    exp_q.delete();
    ret_cnt = 0;
    ack_delay = 0;
    stray = 1'b0;
    model_run(10);
    release_reset();
    wait_retires(3, 100, "mid_restart");
    n_checks++;
    if (ret_cyc[0] !== 4 || ret_pcl[0] !== 8'd0 || ret_data[1] !== 32'd6) begin
      n_fail++;
      $display("FAIL mid_restart: cyc %0d pc %0h data %0h want 4 0 6", ret_cyc[0], ret_pcl[0], ret_data[1]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_beq();
    test_wait();
    test_r0_illegal();
    test_halt();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_core.md
Name: multicycle_core

Overview:
- Parametrised multi-cycle successor to the single-cycle CPU datapath.
- Fetches 32-bit instructions from an external instruction memory over a req/ack handshake, then decodes, executes and writes back over separate states.
- Holds an internal register file and a PC, and adds ADDI, BEQ and HALT to the R-type ALU set.
- Sits at the top of the processor, between instruction memory and the debug/retire observers.

Parameters:
- DATA_W, 32, datapath and register width (≥16).
- PC_W, 8, byte-address width of PC and imem_addr; PC wraps modulo 2^PC_W.
- NREG, 32, number of registers (power of 2, ≤32); register index = low log2(NREG) bits of the 5-bit field.
- RESET_PC, 0, PC value after reset (word aligned).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- imem_req  out  1  fetch request, held until ack.
- imem_addr  out  PC_W  fetch byte address (= PC).
- imem_ack  in  1  memory has imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- retire  out  1  one-cycle pulse per completed instruction.
- retire_pc  out  PC_W  PC of the retiring instruction.
- retire_we  out  1  retiring instruction wrote a register.
- retire_rd  out  5  destination index written.
- retire_data  out  DATA_W  value written.
- illegal  out  1  one-cycle pulse, coincident with retire, on an unknown op/func.
- halted  out  1  core is in HALT.

Behaviour:
- Reset, asynchronous: state=FETCH, PC=RESET_PC, all registers=0, all outputs 0.
- Reset mid-fetch drops imem_req the same instant. A late ack is then ignored.
- Encoding: op=[5:0], rs=[10:6], rt=[15:11], rd=[20:16], func=[31:26], imm16=[31:16] (I-type only).
- States: FETCH -> DECODE -> EXEC -> WB -> FETCH. HALT is terminal.
- FETCH:
  - imem_req=1 with imem_addr=PC, both stable until imem_ack=1 is sampled.
  - On that edge the IR captures imem_rdata and the state moves to DECODE.
  - imem_ack while imem_req=0 is ignored.
- DECODE: register A<=R[rs], B<=R[rt]. An op of 6'h3F goes to HALT instead (retire pulse, no write).
- EXEC: ALU result register <= f(A, B or imm). BEQ resolves its branch here.
- WB:
  - Register write, if any, and PC update.
  - retire, retire_pc, retire_we, retire_rd and retire_data are valid for exactly this cycle.
- Minimum 4 cycles per instruction with zero-wait memory; each memory wait cycle adds 1.
- op 6'h00, R-type, rd <= result, by func:
  - 6'h20 ADD, 6'h22 SUB: modulo 2^DATA_W, no overflow trap.
  - 6'h24 AND, 6'h25 OR, 6'h26 XOR, 6'h27 NOR.
  - 6'h2A SLT: signed; result 1 or 0.
  - 6'h04 SLLV: A << B[log2(DATA_W)-1:0].
- op 6'h08 ADDI: rt <= rs + sign_extend(imm16).
- op 6'h04 BEQ:
  - No register write.
  - If A==B: PC <= PC+4+(sign_extend(imm16)<<2), truncated to PC_W.
  - Otherwise PC <= PC+4.
- All other instructions: PC <= PC+4, wrapping at 2^PC_W.
- Unknown op or R-type func: treated as NOP (no write), illegal=1 in WB.
- Writes to index 0 are discarded: R[0] reads 0 and retire_we=0.
- Read-after-write needs no bypass, because WB completes before the next DECODE.
- HALT:
  - imem_req=0 and halted=1 until RST.
  - PC holds the HALT address.

Decomposition:
- Package multicycle_pkg:
  - opcode constants OP_RTYPE, OP_ADDI, OP_BEQ, OP_HALT.
  - func constants.
  - 3-bit alu_op_t enum: ADD, SUB, AND, OR, XOR, NOR, SLT, SLL.
  - state_t enum: FETCH, DECODE, EXEC, WB, HALT.
- Sub-module core_alu: combinational, parametrised by DATA_W, takes alu_op_t.
- Register file and FSM stay in multicycle_core.

Test Plan:
- Reset, then zero-wait memory running ADDI r1,r0,5 and ADDI r2,r0,-3:
  - Retires at cycles 4 and 8.
  - retire_data 5 then 32'hFFFFFFFD.
  - retire_pc 0 then 4.
- ADD r3,r1,r2 with r1=5, r2=-3, then SLT r4,r2,r1 -> r3=2, r4=1. SUB r5,r2,r1 -> 32'hFFFFFFF8.
- BEQ r1,r1,imm=-2 at PC 8 -> next imem_addr 8+4-8=4. BEQ with r1≠r2 at PC 8 -> next imem_addr 12.
- imem_ack delayed 3 cycles:
  - imem_req and imem_addr stay stable throughout.
  - Retire occurs 3 cycles later than zero-wait.
  - A stray ack while req=0 changes nothing.
- ADDI r0,r0,7 -> retire_we=0, later reads of r0 =0. Unknown func 6'h3E -> illegal=1, no write, PC+4.
- HALT at PC 16 -> retire, then halted=1 and imem_req=0 forever. Asserting RST mid-FETCH -> imem_req=0 immediately, PC=RESET_PC, fetch restarts after release.
